ccsds_stream_checker: RTL and testbench

CCSDS_STREAM_CHECKER -- requirements
Module: ccsds_stream_checker

---
 rtl/ccsds_stream_checker.sv | 143 ++++++++++++++
 tb/tb_ccsds_stream_checker.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ccsds_stream_checker.sv
// ccsds_stream_checker: checks an encoder output stream beat-by-beat against an expected stream.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       one-cycle pulse arming a check run (ignored while running)
//   stim_tvalid, stim_tready    encoder input handshake, monitored for latency only
//   d_tdata/d_tvalid/d_tlast    encoder output stream; d_tready is our ready back to it
//   e_tdata/e_tvalid            expected stream; e_tready pops it in lockstep with accepted beats
//   busy, done, pass            run status
//   err_cnt, beat_cnt           error and accepted-beat counters
//   first_err                   beat index of first error, all-ones when none
//   latency                     cycles from first stim beat to first accepted output beat
module ccsds_stream_checker #(
  parameter int width = 8,
  parameter int frame_len = 160,
  parameter int num_frames = 1,
  parameter int stop_on_err = 1,
  parameter int bp_mode = 0,
  parameter int bp_period = 8,
  parameter int bp_len = 3,
  parameter int cnt_width = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stim_tvalid,
  input  logic                 stim_tready,
  input  logic [width-1:0]     d_tdata,
  input  logic                 d_tvalid,
  input  logic                 d_tlast,
  output logic                 d_tready,
  input  logic [width-1:0]     e_tdata,
  input  logic                 e_tvalid,
  output logic                 e_tready,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [cnt_width-1:0] err_cnt,
  output logic [cnt_width-1:0] beat_cnt,
  output logic [cnt_width-1:0] first_err,
  output logic [cnt_width-1:0] latency
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, HALT} state_e;
  localparam logic [cnt_width-1:0] ones = '1;
  localparam logic [cnt_width-1:0] last_idx = cnt_width'(frame_len - 1);
  localparam logic [cnt_width-1:0] last_frm = cnt_width'(num_frames - 1);
  localparam logic [cnt_width-1:0] bp_top = cnt_width'(bp_period - 1);
  localparam logic [cnt_width-1:0] bp_stall = cnt_width'(bp_len);
  state_e state_q, state_d;
  logic [cnt_width-1:0] phase_q, phase_d, idx_q, idx_d, frame_q, frame_d;
  logic [cnt_width-1:0] beat_q, beat_d, err_q, err_d, first_q, first_d, lat_q, lat_d;
  logic lat_on_q, lat_on_d, lat_fin_q, lat_fin_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic run, bp_ok, acc, stim, bad, end_idx, fin_beat;
  assign run = state_q == RUN;
  assign bp_ok = bp_mode == 0 || phase_q >= bp_stall;
  assign d_tready = run & e_tvalid & bp_ok;
  assign e_tready = d_tvalid & d_tready;
  assign acc = e_tready;
  assign stim = stim_tvalid & stim_tready;
  assign end_idx = idx_q == last_idx;
  // data and tlast mismatches on the same beat collapse into one error
  assign bad = d_tdata != e_tdata || d_tlast != end_idx;
  assign fin_beat = end_idx && frame_q == last_frm;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign err_cnt = err_q;
  assign beat_cnt = beat_q;
  assign first_err = first_q;
  assign latency = lat_q;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d = idx_q;
    frame_d = frame_q;
    beat_d = beat_q;
    err_d = err_q;
    first_d = first_q;
    lat_d = lat_q;
    lat_on_d = lat_on_q;
    lat_fin_d = lat_fin_q;
    if (start && !run) begin
      state_d = RUN;
      phase_d = '0;
      idx_d = '0;
      frame_d = '0;
      beat_d = '0;
      err_d = '0;
      first_d = ones;
      lat_d = '0;
      lat_on_d = 1'b0;
      lat_fin_d = 1'b0;
    end else if (run) begin
      phase_d = phase_q == bp_top ? '0 : phase_q + 1'b1;
      // latency holds 0 on the stim cycle and then counts every cycle until the first accepted beat
      if (lat_on_q && !lat_fin_q) lat_d = lat_q == ones ? lat_q : lat_q + 1'b1;
      if (stim && !lat_fin_q) lat_on_d = 1'b1;
      if (acc) begin
        lat_fin_d = 1'b1;
        beat_d = beat_q + 1'b1;
        idx_d = end_idx ? '0 : idx_q + 1'b1;
        frame_d = end_idx ? frame_q + 1'b1 : frame_q;
        err_d = bad && err_q != ones ? err_q + 1'b1 : err_q;
        first_d = bad && first_q == ones ? beat_q : first_q;
        state_d = bad && stop_on_err != 0 ? HALT : fin_beat ? DONE : RUN;
      end
    end
    busy_d = state_d == RUN;
    done_d = state_d == DONE || state_d == HALT;
    pass_d = state_d == DONE && err_d == '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      idx_q <= '0;
      frame_q <= '0;
      beat_q <= '0;
      err_q <= '0;
      first_q <= ones;
      lat_q <= '0;
      lat_on_q <= 1'b0;
      lat_fin_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q <= idx_d;
      frame_q <= frame_d;
      beat_q <= beat_d;
      err_q <= err_d;
      first_q <= first_d;
      lat_q <= lat_d;
      lat_on_q <= lat_on_d;
      lat_fin_q <= lat_fin_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end
endmodule

// File: tb/tb_ccsds_stream_checker.sv
// tb_ccsds_stream_checker: randomized checking of ccsds_stream_checker against a beat-list reference model
module tb_ccsds_stream_checker;
  localparam int fl = 4;
  localparam int nf = 2;
  localparam int nb = fl * nf;
  logic clk = 0;
  logic rst_n, start, stim_tvalid, stim_tready, d_tvalid, d_tlast, e_tvalid;
  logic [7:0] d_tdata, e_tdata;
  int sel;
  logic dtr [3], etr [3], bsy [3], dn [3], ps [3];
  logic [31:0] ec [3], bc [3], few [3], lt [3];
  logic [7:0] act [nb], exb [nb];
  logic lst [nb];
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    ccsds_stream_checker #(
      .width(8), .frame_len(fl), .num_frames(nf),
      .stop_on_err(g == 1 ? 0 : 1), .bp_mode(g == 2 ? 1 : 0),
      .bp_period(g == 2 ? 4 : 8), .bp_len(g == 2 ? 1 : 3), .cnt_width(32)
    ) dut (
      .clk(clk), .rst_n(rst_n), .start(start && sel == g),
      .stim_tvalid(stim_tvalid), .stim_tready(stim_tready),
      .d_tdata(d_tdata), .d_tvalid(d_tvalid), .d_tlast(d_tlast), .d_tready(dtr[g]),
      .e_tdata(e_tdata), .e_tvalid(e_tvalid), .e_tready(etr[g]),
      .busy(bsy[g]), .done(dn[g]), .pass(ps[g]),
      .err_cnt(ec[g]), .beat_cnt(bc[g]), .first_err(few[g]), .latency(lt[g])
    );
  end
  function automatic int stop_of(input int k); return k == 1 ? 0 : 1; endfunction
  function automatic int bpm_of(input int k); return k == 2 ? 1 : 0; endfunction
  function automatic int per_of(input int k); return k == 2 ? 4 : 8; endfunction
  function automatic int len_of(input int k); return k == 2 ? 1 : 3; endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic load(input bit noisy);
    for (int i = 0; i < nb; i++) begin
      act[i] = 8'($urandom);
      exb[i] = act[i];
      lst[i] = i % fl == fl - 1;
      if (noisy && $urandom_range(9) == 0) exb[i] = act[i] ^ 8'($urandom_range(1, 255));
      if (noisy && $urandom_range(11) == 0) lst[i] = !lst[i];
    end
  endtask
  task automatic chk_reset(input int k);
    chk("rst_busy", bsy[k], 0);
    chk("rst_done", dn[k], 0);
    chk("rst_pass", ps[k], 0);
    chk("rst_err_cnt", ec[k], 0);
    chk("rst_beat_cnt", bc[k], 0);
    chk("rst_first_err", few[k], 32'hFFFF_FFFF);
    chk("rst_latency", lt[k], 0);
    chk("rst_d_tready", dtr[k], 0);
    chk("rst_e_tready", etr[k], 0);
  endtask
  // One run on instance k; the model works purely from the list of accepted beats and cycle timestamps.
  task automatic run_case(input int k, input int stim_at, input int out_from, input int vp, input int ep, input int abort_at);
    int t, j, fs, fa, errs, fe;
    bit live, halted, sv, dv, ev, rdy, er;
    sel = k;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    t = 0; j = 0; fs = -1; fa = -1; errs = 0; fe = -1; live = 1; halted = 0;
    while (live && t < 2000) begin
      if (j == abort_at) begin
        rst_n = 0;
        d_tvalid = 1; e_tvalid = 1;
        #2;
        chk_reset(k);
        @(posedge clk); #1;
        rst_n = 1;
        d_tvalid = 0; e_tvalid = 0;
        return;
      end
      sv = t == stim_at || (t > stim_at && $urandom_range(1) == 1);
      dv = t >= out_from && $urandom_range(99) < vp;
      ev = $urandom_range(99) < ep;
      start = t == 2;
      stim_tvalid = sv; stim_tready = sv;
      d_tvalid = dv; e_tvalid = ev;
      d_tdata = act[j]; e_tdata = exb[j]; d_tlast = lst[j];
      rdy = ev && (bpm_of(k) == 0 || t % per_of(k) >= len_of(k));
      @(negedge clk);
      chk("busy", bsy[k], 1);
      chk("d_tready", dtr[k], rdy);
      chk("e_tready", etr[k], dv && rdy);
      if (sv && fs < 0 && fa < 0) fs = t;
      if (dv && rdy) begin
        if (fa < 0) fa = t;
        er = act[j] != exb[j] || lst[j] != (j % fl == fl - 1);
        if (er) begin
          errs++;
          if (fe < 0) fe = j;
        end
        if (er && stop_of(k) == 1) begin
          live = 0; halted = 1;
        end else if (j == nb - 1) live = 0;
        j++;
      end
      @(posedge clk); #1;
      t++;
    end
    start = 0;
    stim_tvalid = 0; stim_tready = 0;
    if (live) chk("timeout", 1, 0);
    d_tvalid = 1; e_tvalid = 1;
    #1;
    chk("end_d_tready", dtr[k], 0);
    chk("end_e_tready", etr[k], 0);
    chk("end_busy", bsy[k], 0);
    chk("end_done", dn[k], 1);
    chk("end_pass", ps[k], !halted && errs == 0);
    chk("end_err_cnt", ec[k], errs);
    chk("end_beat_cnt", bc[k], j);
    chk("end_first_err", few[k], fe < 0 ? 32'hFFFF_FFFF : fe);
    chk("end_latency", lt[k], fs >= 0 ? fa - fs : 0);
    @(posedge clk); #1;
    chk("hold_done", dn[k], 1);
    chk("hold_beat_cnt", bc[k], j);
    d_tvalid = 0; e_tvalid = 0;
  endtask
  initial begin
    rst_n = 0; start = 0; sel = 0;
    stim_tvalid = 0; stim_tready = 0;
    d_tvalid = 1; e_tvalid = 1; d_tlast = 0; d_tdata = 0; e_tdata = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_reset(k);
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("idle_d_tready", dtr[k], 0);
      chk("idle_beat_cnt", bc[k], 0);
      chk("idle_busy", bsy[k], 0);
    end
    d_tvalid = 0; e_tvalid = 0;
    load(0);
    run_case(0, 0, 0, 100, 100, -1);
    load(0);
    run_case(0, 10, 25, 100, 100, -1);
    load(0);
    act[5] = 8'hA5; exb[5] = 8'h5A;
    run_case(0, 0, 0, 100, 100, -1);
    load(0);
    lst[2] = 1;
    act[6] = ~exb[6];
    run_case(1, 0, 0, 100, 100, -1);
    load(0);
    run_case(2, 0, 0, 100, 100, -1);
    load(0);
    run_case(0, 1, 0, 100, 100, 3);
    load(0);
    run_case(0, 0, 0, 100, 100, -1);
    for (int r = 0; r < 24; r++) begin
      load(1);
      run_case(r % 3, $urandom_range(0, 6), $urandom_range(0, 6), 60, 70, -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
